// File: rtl/mac_seq_ctrl_pkg.sv
// Shared types and default parameters for the MAC sequencer.
// Used by the top controller and by its valid delay line.
package mac_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_MUL_LAT = 10;
  localparam int DEF_LEN_W   = 8;

endpackage

// File: rtl/mac_seq_ctrl_valid_delay_line.sv
// Valid tag delay line that runs alongside the multiply pipeline; its output
// marks the cycle in which a product leaves the pipeline.
module valid_delay_line
  import mac_seq_ctrl_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic clock,
  input  logic clear,
  input  logic din,
  output logic dout
);

  logic [MUL_LAT:0] tap;

  assign tap[0] = din;

  genvar i;
  generate
    for (i = 0; i < MUL_LAT; i++) begin : g_stage
      logic stage_d;
      logic stage_q;

      always_comb begin
        stage_d = clear ? 1'b0 : tap[i];
      end

      always_ff @(posedge clock) begin
        stage_q <= stage_d;
      end

      assign tap[i+1] = stage_q;
    end
  endgenerate

  assign dout = tap[MUL_LAT];

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product job sequencer: admits N operand pairs into the multiply pipeline,
// flags each product for accumulation as it emerges, then holds the result.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_RUN   | accepting operand pairs
// ST_DRAIN | all operands issued, waiting for the final products
// ST_DONE  | result final, waiting for result_ready
module mac_seq_ctrl
  import mac_seq_ctrl_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             mul_issue,
  output logic             acc_clear,
  output logic             acc_en,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] issued_cnt_q, issued_cnt_d;
  logic [LEN_W-1:0] retired_cnt_q, retired_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             result_valid_q, result_valid_d;
  logic             busy_q, busy_d;
  logic             accept;
  logic             product_out;
  logic [LEN_W-1:0] last_idx;

  assign accept    = in_valid & in_ready_q;
  assign mul_issue = accept;
  assign acc_en    = product_out;
  assign last_idx  = len_q - LEN_W'(1);
  // Gated by reset so a start held through reset cannot wipe the accumulator.
  assign acc_clear = ~reset & start & (state_q == ST_IDLE);

  assign in_ready     = in_ready_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;

  valid_delay_line #(
    .MUL_LAT(MUL_LAT)
  ) u_valid_dl (
    .clock(clock),
    .clear(reset),
    .din  (accept),
    .dout (product_out)
  );

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    issued_cnt_d  = issued_cnt_q;
    retired_cnt_d = retired_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d         = vec_len;
          issued_cnt_d  = '0;
          retired_cnt_d = '0;
          state_d       = (vec_len != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (accept) begin
          issued_cnt_d = issued_cnt_q + LEN_W'(1);
          if (issued_cnt_q == last_idx) state_d = ST_DRAIN;
        end
        // The final retirement wins over the last issue when both coincide.
        if (product_out) begin
          retired_cnt_d = retired_cnt_q + LEN_W'(1);
          if (retired_cnt_q == last_idx) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    in_ready_d     = (state_d == ST_RUN);
    result_valid_d = (state_d == ST_DONE);
    busy_d         = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      issued_cnt_q   <= '0;
      retired_cnt_q  <= '0;
      in_ready_q     <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      issued_cnt_q   <= issued_cnt_d;
      retired_cnt_q  <= retired_cnt_d;
      in_ready_q     <= in_ready_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: table of jobs with a scoreboard of
// expected acc_en cycles, plus hand-written backpressure and reset sequences.
module tb_mac_seq_ctrl;

  localparam int MUL_LAT = 10;
  localparam int LEN_W   = 8;

  logic             clock;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] vec_len;
  logic             in_valid;
  logic             in_ready;
  logic             mul_issue;
  logic             acc_clear;
  logic             acc_en;
  logic             result_valid;
  logic             result_ready;
  logic             busy;

  mac_seq_ctrl #(
    .MUL_LAT(MUL_LAT),
    .LEN_W  (LEN_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .vec_len     (vec_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mul_issue   (mul_issue),
    .acc_clear   (acc_clear),
    .acc_en      (acc_en),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .busy        (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    int          len;
    logic [15:0] pat;
    int          rv;
    int          hold;
  } job_t;

  job_t jobs[6];
  int   exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle 0 is the cycle in which start is driven; inputs change at negedge,
  // outputs are sampled 1 time unit later.
  task automatic run_job(input job_t j);
    int  acc_cnt;
    bit  seen;
    bit  exp_rdy;
    bit  exp_iss;
    bit  exp_acc;
    @(negedge clock);
    start    = 1'b1;
    vec_len  = LEN_W'(j.len);
    in_valid = 1'b0;
    #1;
    chk({j.name, " acc_clear_c0"}, acc_clear, 1);
    chk({j.name, " busy_c0"}, busy, 0);
    acc_cnt = 0;
    seen    = 1'b0;
    for (int c = 1; c <= 60 && !seen; c++) begin
      @(negedge clock);
      start    = 1'b0;
      in_valid = (c <= 16) ? j.pat[c-1] : 1'b0;
      #1;
      exp_rdy = (acc_cnt < j.len);
      exp_iss = exp_rdy && in_valid;
      chk({j.name, " in_ready"}, in_ready, exp_rdy);
      chk({j.name, " mul_issue"}, mul_issue, exp_iss);
      if (exp_iss) begin
        exp_q.push_back(c + MUL_LAT);
        acc_cnt++;
      end
      exp_acc = (exp_q.size() > 0) && (exp_q[0] == c);
      chk({j.name, " acc_en"}, acc_en, exp_acc);
      if (exp_acc) void'(exp_q.pop_front());
      chk({j.name, " acc_clear_run"}, acc_clear, 0);
      chk({j.name, " busy"}, busy, 1);
      if (result_valid) begin
        seen = 1'b1;
        chk({j.name, " rv_cycle"}, c, j.rv);
        chk({j.name, " pending_products"}, exp_q.size(), 0);
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s timeout: result_valid never rose, expected cycle %0d", j.name, j.rv);
    end
    for (int h = 0; h < j.hold; h++) begin
      @(negedge clock);
      start    = (h == 1) || (h == 3);
      vec_len  = 8'd7;
      in_valid = 1'b1;
      #1;
      chk({j.name, " hold_rv"}, result_valid, 1);
      chk({j.name, " hold_in_ready"}, in_ready, 0);
      chk({j.name, " hold_acc_clear"}, acc_clear, 0);
      chk({j.name, " hold_busy"}, busy, 1);
      chk({j.name, " hold_acc_en"}, acc_en, 0);
    end
    result_ready = 1'b1;
    start        = (j.hold > 0);
    @(negedge clock);
    result_ready = 1'b0;
    start        = 1'b0;
    in_valid     = 1'b0;
    #1;
    chk({j.name, " rv_after_ack"}, result_valid, 0);
    chk({j.name, " busy_after_ack"}, busy, 0);
    @(negedge clock);
    #1;
    chk({j.name, " idle_stays"}, busy, 0);
    chk({j.name, " idle_acc_en"}, acc_en, 0);
    exp_q.delete();
  endtask

  initial begin
    jobs[0] = '{name: "b2b_len3",   len: 3,  pat: 16'hFFFF, rv: 14, hold: 0};
    jobs[1] = '{name: "bubbles",    len: 4,  pat: 16'h002D, rv: 17, hold: 0};
    jobs[2] = '{name: "zero_len",   len: 0,  pat: 16'hFFFF, rv: 1,  hold: 0};
    jobs[3] = '{name: "long_len12", len: 12, pat: 16'hFFFF, rv: 23, hold: 0};
    jobs[4] = '{name: "len1",       len: 1,  pat: 16'h0001, rv: 12, hold: 0};
    jobs[5] = '{name: "backpress",  len: 2,  pat: 16'hFFFF, rv: 13, hold: 5};

    reset        = 1'b1;
    start        = 1'b0;
    vec_len      = '0;
    in_valid     = 1'b0;
    result_ready = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset in_ready", in_ready, 0);
    chk("reset mul_issue", mul_issue, 0);
    chk("reset acc_clear", acc_clear, 0);
    chk("reset acc_en", acc_en, 0);
    chk("reset result_valid", result_valid, 0);
    chk("reset busy", busy, 0);

    for (int i = 0; i < 6; i++) run_job(jobs[i]);

    // Reset in cycle 8 while five products are still in the pipeline.
    @(negedge clock);
    start    = 1'b1;
    vec_len  = 8'd5;
    in_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      start    = 1'b0;
      in_valid = 1'b1;
      reset    = (c == 8);
      #1;
      if (c == 7) begin
        chk("midrst in_ready_drain", in_ready, 0);
        chk("midrst busy_drain", busy, 1);
      end
    end
    @(negedge clock);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst in_ready", in_ready, 0);
    chk("midrst mul_issue", mul_issue, 0);
    chk("midrst acc_clear", acc_clear, 0);
    chk("midrst acc_en", acc_en, 0);
    chk("midrst result_valid", result_valid, 0);
    chk("midrst busy", busy, 0);
    for (int k = 0; k < 15; k++) begin
      @(negedge clock);
      #1;
      chk("midrst no_acc_en", acc_en, 0);
      chk("midrst stays_idle", busy, 0);
    end
    run_job(jobs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
